// File: rtl/memwb_pipe_reg_if.sv
// MEM->WB pipeline register bus: M-stage request side, W-stage result side and the stall/flush controls.
// The master drives M fields plus En/Flush; the slave (the pipeline register) returns W fields.
interface memwb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic              En;
  logic              Flush;
  logic              ValidM;
  logic [DATA_W-1:0] ReadDataM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] PCPlus8M;
  logic [REG_W-1:0]  WriteRegM;
  logic              RegWriteM;
  logic [1:0]        MemtoRegM;

  logic              ValidW;
  logic [DATA_W-1:0] ReadDataW;
  logic [DATA_W-1:0] ALUOutW;
  logic [DATA_W-1:0] PCPlus8W;
  logic [REG_W-1:0]  WriteRegW;
  logic [1:0]        MemtoRegW;
  logic              RegWriteW;
  logic [DATA_W-1:0] ResultW;
  logic [CNT_W-1:0]  RetireCnt;

  modport master (
    output En, Flush, ValidM, ReadDataM, ALUOutM, PCPlus8M, WriteRegM, RegWriteM, MemtoRegM,
    input  ValidW, ReadDataW, ALUOutW, PCPlus8W, WriteRegW, MemtoRegW, RegWriteW, ResultW, RetireCnt
  );

  modport slave (
    input  En, Flush, ValidM, ReadDataM, ALUOutM, PCPlus8M, WriteRegM, RegWriteM, MemtoRegM,
    output ValidW, ReadDataW, ALUOutW, PCPlus8W, WriteRegW, MemtoRegW, RegWriteW, ResultW, RetireCnt
  );
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM->WB register chain of DEPTH stages; latency DEPTH edges with En=1.
// En=0 holds every stage (no loss or duplication); Flush turns stage 1 into a bubble.
module memwb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  memwb_pipe_reg_if.slave  bus
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : gDepthCheck
      $error("memwb_pipe_reg: DEPTH must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] pcPlus8;
    logic [REG_W-1:0]  writeReg;
    logic              regWrite;
    logic [1:0]        memtoReg;
  } stage_t;

  stage_t           stg [DEPTH];
  stage_t           mIn;
  stage_t           wSt;
  logic [CNT_W-1:0] retireCnt;

  always_comb begin
    mIn          = '0;
    mIn.valid    = bus.ValidM;
    mIn.readData = bus.ReadDataM;
    mIn.aluOut   = bus.ALUOutM;
    mIn.pcPlus8  = bus.PCPlus8M;
    mIn.writeReg = bus.WriteRegM;
    mIn.regWrite = bus.RegWriteM;
    mIn.memtoReg = bus.MemtoRegM;
  end

  // Stage 1 takes flush priority over stall; later stages only care about En.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      retireCnt <= '0;
    end else begin
      if (bus.Flush)   stg[0] <= '0;
      else if (bus.En) stg[0] <= mIn;
      for (int k = 1; k < DEPTH; k++) begin
        if (bus.En) stg[k] <= stg[k-1];
      end
      if (bus.En && stg[DEPTH-1].valid) retireCnt <= retireCnt + CNT_W'(1);
    end
  end

  assign wSt = stg[DEPTH-1];

  assign bus.ValidW    = wSt.valid;
  assign bus.ReadDataW = wSt.readData;
  assign bus.ALUOutW   = wSt.aluOut;
  assign bus.PCPlus8W  = wSt.pcPlus8;
  assign bus.WriteRegW = wSt.writeReg;
  assign bus.MemtoRegW = wSt.memtoReg;
  assign bus.RetireCnt = retireCnt;

  // Bubbles and writes to $0 must never reach the register file.
  assign bus.RegWriteW = wSt.regWrite & wSt.valid & (wSt.writeReg != '0);

  always_comb begin
    bus.ResultW = '0;
    case (wSt.memtoReg)
      2'd0:    bus.ResultW = wSt.aluOut;
      2'd1:    bus.ResultW = wSt.readData;
      2'd2:    bus.ResultW = wSt.pcPlus8;
      default: bus.ResultW = '0;
    endcase
  end

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Drives DEPTH=1..4 instances with shared stimulus and checks each against a queue-based model.
module tb_memwb_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        rw;
    logic [1:0]  sel;
  } txn_t;

  logic Clk;
  logic Reset;
  logic En;
  logic Flush;
  txn_t mIn;

  logic [3:0]       validW, rwW;
  logic [3:0][31:0] resultW, aluW, rdW, pcW, cntW;
  logic [3:0][4:0]  wrW;
  logic [3:0][1:0]  selW;

  txn_t        pipe [4][$];
  logic [31:0] cnt  [4];
  int          nvec = 0;
  int          nerr = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 4; g++) begin : gd
    memwb_pipe_reg_if bus ();
    memwb_pipe_reg #(.DEPTH(g + 1)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

    assign bus.En        = En;
    assign bus.Flush     = Flush;
    assign bus.ValidM    = mIn.valid;
    assign bus.ReadDataM = mIn.rd;
    assign bus.ALUOutM   = mIn.alu;
    assign bus.PCPlus8M  = mIn.pc;
    assign bus.WriteRegM = mIn.wr;
    assign bus.RegWriteM = mIn.rw;
    assign bus.MemtoRegM = mIn.sel;

    assign validW[g]  = bus.ValidW;
    assign rwW[g]     = bus.RegWriteW;
    assign resultW[g] = bus.ResultW;
    assign aluW[g]    = bus.ALUOutW;
    assign rdW[g]     = bus.ReadDataW;
    assign pcW[g]     = bus.PCPlus8W;
    assign cntW[g]    = bus.RetireCnt;
    assign wrW[g]     = bus.WriteRegW;
    assign selW[g]    = bus.MemtoRegW;
  end

  function automatic logic [31:0] result_of(input txn_t t);
    case (t.sel)
      2'd0:    return t.alu;
      2'd1:    return t.rd;
      2'd2:    return t.pc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s depth=%0d observed=%h expected=%h", tag, g + 1, obs, exp);
    end
  endtask

  // Model: each instance is a fixed-length queue of in-flight instructions, newest at the front.
  task automatic model_edge();
    txn_t bub;
    bub = '0;
    for (int g = 0; g < 4; g++) begin
      if (Reset) begin
        pipe[g].delete();
        for (int k = 0; k <= g; k++) pipe[g].push_back(bub);
        cnt[g] = 0;
      end else begin
        if (En && pipe[g][g].valid) cnt[g] = cnt[g] + 1;
        if (En) begin
          pipe[g].push_front(Flush ? bub : mIn);
          void'(pipe[g].pop_back());
        end else if (Flush) begin
          pipe[g][0] = bub;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      txn_t w;
      w = pipe[g][g];
      chk("ValidW",    g, 32'(validW[g]),  32'(w.valid));
      chk("RegWriteW", g, 32'(rwW[g]),     32'(w.valid & w.rw & (w.wr != 5'd0)));
      chk("ResultW",   g, resultW[g],      result_of(w));
      chk("ALUOutW",   g, aluW[g],         w.alu);
      chk("ReadDataW", g, rdW[g],          w.rd);
      chk("PCPlus8W",  g, pcW[g],          w.pc);
      chk("WriteRegW", g, 32'(wrW[g]),     32'(w.wr));
      chk("MemtoRegW", g, 32'(selW[g]),    32'(w.sel));
      chk("RetireCnt", g, cntW[g],         cnt[g]);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] pc, input logic [4:0] wr, input logic rw,
                        input logic [1:0] sel);
    mIn.valid = v;
    mIn.alu   = alu;
    mIn.rd    = rd;
    mIn.pc    = pc;
    mIn.wr    = wr;
    mIn.rw    = rw;
    mIn.sel   = sel;
  endtask

  task automatic rand_in();
    mIn.valid = ($urandom_range(0, 3) != 0);
    mIn.alu   = $urandom;
    mIn.rd    = $urandom;
    mIn.pc    = $urandom;
    mIn.wr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    mIn.rw    = 1'($urandom_range(0, 1));
    mIn.sel   = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [31:0] savedCnt;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k <= g; k++) pipe[g].push_back('0);
      cnt[g] = 0;
    end
    Reset = 1'b1; En = 1'b1; Flush = 1'b0;
    set_in(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 2'd1);
    tick();
    tick();
    chk("reset_ResultW", 0, resultW[3], 32'd0);
    chk("reset_Cnt", 0, cntW[3], 32'd0);
    Reset = 1'b0;

    // Basic flow through DEPTH=1.
    set_in(1'b1, 32'h0000_1234, 32'd0, 32'd0, 5'd8, 1'b1, 2'd0);
    tick();
    chk("basic_ValidW", 0, 32'(validW[0]), 32'd1);
    chk("basic_RegWriteW", 0, 32'(rwW[0]), 32'd1);
    chk("basic_ResultW", 0, resultW[0], 32'h0000_1234);
    set_in(1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 32'd0, 5'd9, 1'b1, 2'd1);
    tick();
    chk("basic_RetireCnt", 0, cntW[0], 32'd1);
    chk("sel1_ResultW", 0, resultW[0], 32'hDEAD_BEEF);
    set_in(1'b1, 32'h0000_0002, 32'd5, 32'h0000_3008, 5'd31, 1'b1, 2'd2);
    tick();
    chk("sel2_ResultW", 0, resultW[0], 32'h0000_3008);

    // $0 write suppression, then a flushed instruction.
    set_in(1'b1, 32'h0000_0003, 32'd0, 32'd0, 5'd0, 1'b1, 2'd0);
    tick();
    chk("reg0_RegWriteW", 0, 32'(rwW[0]), 32'd0);
    set_in(1'b1, 32'h0000_0004, 32'd0, 32'd0, 5'd7, 1'b1, 2'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_ValidW", 0, 32'(validW[0]), 32'd0);
    chk("flush_RegWriteW", 0, 32'(rwW[0]), 32'd0);
    savedCnt = cntW[0];
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
    tick();
    chk("flush_CntHeld", 0, cntW[0], savedCnt);

    // DEPTH=3 stall: tags 1,2 then two stall cycles, then tag 3.
    Reset = 1'b1; tick(); Reset = 1'b0;
    set_in(1'b1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1, 2'd0); tick();
    set_in(1'b1, 32'd2, 32'd0, 32'd0, 5'd2, 1'b1, 2'd0); tick();
    set_in(1'b1, 32'd3, 32'd0, 32'd0, 5'd3, 1'b1, 2'd0);
    En = 1'b0; tick(); tick(); En = 1'b1;
    chk("stall_heldValidW", 2, 32'(validW[2]), 32'd0);
    tick();
    chk("stall_tag1_edge5", 2, aluW[2], 32'd1);
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
    tick();
    chk("stall_tag2", 2, aluW[2], 32'd2);
    tick();
    chk("stall_tag3", 2, aluW[2], 32'd3);
    tick();
    chk("stall_RetireCnt", 2, cntW[2], 32'd3);

    // DEPTH=2 flush while stalled.
    Reset = 1'b1; tick(); Reset = 1'b0;
    set_in(1'b1, 32'hA, 32'd0, 32'd0, 5'd4, 1'b1, 2'd0); tick();
    set_in(1'b1, 32'hB, 32'd0, 32'd0, 5'd5, 1'b1, 2'd0); tick();
    En = 1'b0; Flush = 1'b1; tick(); Flush = 1'b0; En = 1'b1;
    chk("fstall_ValidW", 1, 32'(validW[1]), 32'd1);
    chk("fstall_ALUOutW", 1, aluW[1], 32'hA);
    chk("fstall_Cnt", 1, cntW[1], 32'd0);
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
    tick();
    tick();
    chk("fstall_bubbleNoRetire", 1, cntW[1], 32'd1);

    // Reset with every pipeline full of valid work.
    for (int i = 0; i < 4; i++) begin
      rand_in(); mIn.valid = 1'b1; mIn.wr = 5'd6; mIn.rw = 1'b1; mIn.sel = 2'd1; mIn.rd = 32'h55;
      tick();
    end
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk("midreset_ValidW", g, 32'(validW[g]), 32'd0);
      chk("midreset_ResultW", g, resultW[g], 32'd0);
      chk("midreset_Cnt", g, cntW[g], 32'd0);
    end
    set_in(1'b1, 32'h77, 32'd0, 32'd0, 5'd3, 1'b1, 2'd0);
    tick();
    chk("postreset_ValidW", 0, 32'(validW[0]), 32'd1);
    chk("postreset_ResultW", 0, resultW[0], 32'h77);

    // Random traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      En    = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    Reset = 1'b0; En = 1'b1; Flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memwb_pipe_reg.md
Name: memwb_pipe_reg

Overview:
- Parametrised MEM→WB pipeline register for the 5-stage MIPS core.
- Delay is configurable from 1 to 4 stages, with stall (hold), flush (bubble insert) and a per-stage valid bit.
- Qualifies register write-enable (invalid or $0 writes are suppressed) and provides the registered write-back result select.
- Keeps a retired-instruction counter for the bench and performance readout.

Parameters:
- DATA_W, 32, width of ReadData, ALUOut and PCPlus8 fields.
- REG_W, 5, width of the destination register index.
- DEPTH, 1, number of register stages between M and W; legal range 1..4.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  advance enable; 0 = stall, all stages hold.
- Flush  in  1  load a bubble into stage 1.
- ValidM  in  1  M-stage instruction is real (not a bubble).
- ReadDataM  in  DATA_W  data-memory read value.
- ALUOutM  in  DATA_W  ALU result / address.
- PCPlus8M  in  DATA_W  link address for jal/jalr.
- WriteRegM  in  REG_W  destination register.
- RegWriteM  in  1  register write request.
- MemtoRegM  in  2  result select.
- ValidW  out  1  final stage holds a real instruction.
- ReadDataW, ALUOutW, PCPlus8W  out  DATA_W  final-stage fields.
- WriteRegW  out  REG_W  final-stage destination.
- MemtoRegW  out  2  final-stage select.
- RegWriteW  out  1  qualified write enable.
- ResultW  out  DATA_W  write-back value.
- RetireCnt  out  CNT_W  count of instructions retired.

Behaviour:
- Reset is synchronous, active-high, on Clk rising edge.
  - Every stage's fields and valid bit clear to 0; RetireCnt clears to 0.
  - All outputs therefore read 0, including RegWriteW and ResultW (MemtoRegW = 0 selects ALUOutW = 0).
  - Reset overrides En and Flush.
- Pipeline chain is stage 1 .. stage DEPTH. The W outputs are stage DEPTH.
  - With DEPTH = 1, this block is equivalent to the existing MEM/WB register plus valid, stall and flush.
- Latency: with En held at 1, M inputs appear at W outputs exactly DEPTH rising edges later.
- En = 1, Flush = 0: stage 1 loads the M inputs; stage k loads stage k-1.
- En = 0, Flush = 0: every stage holds; no data is lost or duplicated.
- Flush = 1 (any En):
  - Stage 1 loads a bubble: valid = 0, RegWrite = 0; other fields are don't-care, implemented as 0.
  - If En = 1, stages 2..DEPTH advance; if En = 0, stages 2..DEPTH hold.
  - The M-stage instruction is discarded.
- RegWriteW = stage DEPTH RegWrite AND ValidW AND (WriteRegW != 0). This is combinational from registered state.
- ResultW is combinational from registered stage-DEPTH fields:
  - MemtoRegW = 0 → ALUOutW
  - MemtoRegW = 1 → ReadDataW
  - MemtoRegW = 2 → PCPlus8W
  - MemtoRegW = 3 → 0
- RetireCnt increments by 1 on a rising edge where En = 1, Reset = 0 and ValidW = 1 (the instruction leaves the final stage).
  - Flush does not block the increment, because flush only affects stage 1.
  - Wraps modulo 2^CNT_W with no saturation.
- Field widths are carried unchanged; no arithmetic on data fields.
- DEPTH outside 1..4 is an elaboration error via a generate-time check.
- Reset asserted mid-stream kills all in-flight instructions; nothing retires on the reset edge.

Test Plan:
- DEPTH=1 basic flow: ValidM=1, ALUOutM=0x0000_1234, WriteRegM=8, RegWriteM=1, MemtoRegM=0, En=1 → after 1 edge: ValidW=1, RegWriteW=1, ResultW=0x0000_1234; RetireCnt=1 after the next edge.
- Result select: MemtoRegM=1 with ReadDataM=0xDEAD_BEEF, then MemtoRegM=2 with PCPlus8M=0x0000_3008 → ResultW = 0xDEAD_BEEF, then 0x0000_3008.
- $0 and bubble suppression: WriteRegM=0, RegWriteM=1, ValidM=1 → RegWriteW=0. Then Flush=1 with RegWriteM=1 → next W has ValidW=0, RegWriteW=0, and RetireCnt is unchanged one edge later.
- DEPTH=3 stall: feed 3 instructions tagged ALUOut 1, 2, 3; drop En=0 for 2 cycles after the second edge → W outputs hold, no duplication. Resume; tag 1 reaches W at edge 5, tags arrive in order, and RetireCnt ends at 3.
- Flush during stall, DEPTH=2: En=0, Flush=1 → stage 1 becomes a bubble, stage 2 and ValidW are held. Release En → the bubble reaches W and RetireCnt does not increment for it.
- Reset mid-operation: a pipeline full of valid instructions, assert Reset 1 cycle → all W outputs 0, RetireCnt=0, ResultW=0; normal flow resumes on the first edge after Reset drops.
